// File: rtl/uart_pkt_pkg.sv
// Shared constants, serializer state encoding and the packet checksum
// used by the UART packet transmitter.
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 4;
  localparam int         CNT_W       = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Checksum covers every byte that precedes it in the packet.
  function automatic logic [7:0] pkt_checksum(input logic [3:0] ch, input logic [7:0] d);
    return SYNC_BYTE ^ {4'h0, ch} ^ d;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each
// held CLKS_PER_BIT cycles; uart line is registered and idles high.
module uart_tx_byte
  import uart_pkt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  // Handshake: a byte transfers on any rising edge where in_valid and
  // in_ready are both high. in_ready is high in IDLE and during the last
  // cycle of a stop bit, so a byte offered then starts with no idle gap.
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       tx,
  output tx_state_e  state
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic             tick;
  logic             fire;

  assign tick     = (cnt_q == BIT_LAST);
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick);
  assign fire     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fire) state_d = ST_START;
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA:  if (tick && (bit_q == 3'd7)) state_d = ST_STOP;
      ST_STOP:  if (tick) state_d = fire ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // tx is computed from the next state so the registered line lines up
  // with the state it belongs to.
  always_comb begin
    cnt_d  = ((state_q == ST_IDLE) || tick) ? '0 : cnt_q + 1'b1;
    bit_d  = ((state_q == ST_DATA) && tick) ? bit_q + 3'd1 : bit_q;
    data_d = fire ? in_data : data_q;
    tx_d   = 1'b1;
    case (state_d)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = data_q[bit_d];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx    = tx_q;
  assign state = state_q;

endmodule

// File: rtl/uart_pkt_tx.sv
// Sends a 4-byte status packet (SYNC, channel, duty, checksum) over UART,
// feeding bytes into uart_tx_byte back-to-back and flagging busy/done.
module uart_pkt_tx
  import uart_pkt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [3:0] ch_id,
  input  logic [7:0] duty,
  output logic       busy,
  output logic       done,
  output logic       uart_tx
);

  localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

  logic       active_q;
  logic [1:0] byte_q;
  logic [3:0] ch_q;
  logic [7:0] duty_q;

  tx_state_e  tx_state;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  logic       byte_end;
  logic       last_byte_end;
  logic       accept;
  logic [1:0] next_byte;

  assign byte_end      = active_q && tx_ready && (tx_state == ST_STOP);
  assign last_byte_end = byte_end && (byte_q == LAST_BYTE);

  // busy drops in the final stop-bit cycle so a new send can chain with no gap.
  assign done      = last_byte_end;
  assign busy      = active_q && !last_byte_end;
  assign accept    = send && !busy;
  assign next_byte = byte_q + 2'd1;

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = SYNC_BYTE;
    if (accept) begin
      tx_valid = 1'b1;
      tx_data  = SYNC_BYTE;
    end else if (byte_end && !last_byte_end) begin
      tx_valid = 1'b1;
      case (next_byte)
        2'd1:    tx_data = {4'h0, ch_q};
        2'd2:    tx_data = duty_q;
        2'd3:    tx_data = pkt_checksum(ch_q, duty_q);
        default: tx_data = SYNC_BYTE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      byte_q   <= '0;
      ch_q     <= '0;
      duty_q   <= '0;
    end else if (accept) begin
      active_q <= 1'b1;
      byte_q   <= '0;
      ch_q     <= ch_id;
      duty_q   <= duty;
    end else if (byte_end) begin
      if (last_byte_end) begin
        active_q <= 1'b0;
        byte_q   <= '0;
      end else begin
        byte_q   <= next_byte;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (tx_valid),
    .in_ready (tx_ready),
    .in_data  (tx_data),
    .tx       (uart_tx),
    .state    (tx_state)
  );

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Directed bench for uart_pkt_tx at CLKS_PER_BIT=4: checks every line cycle
// of each packet against hand-computed byte streams.
module tb_uart_pkt_tx;

  localparam int CPB = 4;
  localparam int PKT_CYCLES = 40 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       send = 1'b0;
  logic [3:0] ch_id = 4'h0;
  logic [7:0] duty = 8'h00;
  logic       busy;
  logic       done;
  logic       uart_tx;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  uart_pkt_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .send    (send),
    .ch_id   (ch_id),
    .duty    (duty),
    .busy    (busy),
    .done    (done),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
  endtask

  // Presents send for one edge (or leaves it high when hold is set).
  task automatic start_pkt(input logic [3:0] c, input logic [7:0] d, input bit hold);
    @(negedge clk);
    ch_id = c;
    duty  = d;
    send  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) send = 1'b0;
  endtask

  // Checks all cycles of one packet: line level, busy, done.
  task automatic rx_packet();
    logic [7:0] b [4];
    if (exp_q.size() < 4) begin
      check("exp_q_underflow", 32'(exp_q.size()), 32'd4);
      return;
    end
    for (int i = 0; i < 4; i++) b[i] = exp_q.pop_front();
    for (int c = 1; c <= PKT_CYCLES; c++) begin
      int   k;
      int   bi;
      int   pos;
      logic eb;
      @(negedge clk);
      k   = (c - 1) / CPB;
      bi  = k / 10;
      pos = k % 10;
      if (pos == 0)      eb = 1'b0;
      else if (pos == 9) eb = 1'b1;
      else               eb = b[bi][pos-1];
      check($sformatf("tx_bit byte%0d pos%0d cyc%0d", bi, pos, c), 32'(uart_tx), 32'(eb));
      check($sformatf("busy cyc%0d", c), 32'(busy), 32'(c != PKT_CYCLES));
      check($sformatf("done cyc%0d", c), 32'(done), 32'(c == PKT_CYCLES));
    end
  endtask

  task automatic check_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_tx"}, 32'(uart_tx), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    check_idle(3, "post_rst");

    // Basic packet: 0xA5 ^ 0x03 ^ 0x80 = 0x26
    push_pkt(8'hA5, 8'h03, 8'h80, 8'h26);
    start_pkt(4'h3, 8'h80, 1'b0);
    rx_packet();
    check_idle(4, "idle_a");

    // All-ones payload: 0xA5 ^ 0x0F ^ 0xFF = 0x55
    push_pkt(8'hA5, 8'h0F, 8'hFF, 8'h55);
    start_pkt(4'hF, 8'hFF, 1'b0);
    rx_packet();
    check_idle(2, "idle_b");

    // Send pulsed mid-packet is dropped: 0xA5 ^ 0x01 ^ 0x22 = 0x86
    push_pkt(8'hA5, 8'h01, 8'h22, 8'h86);
    start_pkt(4'h1, 8'h22, 1'b0);
    fork
      rx_packet();
      begin
        repeat (49) @(negedge clk);
        #1;
        ch_id = 4'h6;
        duty  = 8'h77;
        send  = 1'b1;
        @(negedge clk);
        #1;
        send  = 1'b0;
      end
    join
    check_idle(20, "no_queue");

    // Inputs changed after acceptance do not leak into the packet.
    push_pkt(8'hA5, 8'h03, 8'h80, 8'h26);
    start_pkt(4'h3, 8'h80, 1'b0);
    fork
      rx_packet();
      begin
        @(negedge clk);
        @(negedge clk);
        #1;
        duty  = 8'h11;
        ch_id = 4'hC;
      end
    join
    check_idle(2, "idle_c");

    // send held high: two packets, second starts right after first stop bit.
    // 0xA5 ^ 0x02 ^ 0x40 = 0xE7
    push_pkt(8'hA5, 8'h02, 8'h40, 8'hE7);
    push_pkt(8'hA5, 8'h02, 8'h40, 8'hE7);
    start_pkt(4'h2, 8'h40, 1'b1);
    fork
      begin
        rx_packet();
        rx_packet();
      end
      begin
        repeat (200) @(negedge clk);
        #1;
        send = 1'b0;
      end
    join
    check_idle(4, "idle_d");

    // Reset in the middle of a packet aborts it at once.
    start_pkt(4'h7, 8'h5A, 1'b0);
    repeat (69) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tx", 32'(uart_tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_idle(4, "in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(2, "after_rst");

    // Clean packet after reset: 0xA5 ^ 0x05 ^ 0x3C = 0x9C
    push_pkt(8'hA5, 8'h05, 8'h3C, 8'h9C);
    start_pkt(4'h5, 8'h3C, 1'b0);
    rx_packet();
    check_idle(3, "idle_e");

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
